// File: rtl/game_pkg.sv
// Shared VGA road-crossing game constants and the car position wrap helper.
package game_pkg;

  localparam int H_DISPLAY    = 640;
  localparam int H_FRONT      = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BACK       = 48;
  localparam int V_DISPLAY    = 480;
  localparam int V_FRONT      = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BACK       = 33;
  localparam int LANE_Y0      = 320;
  localparam int LANE_HEIGHT  = 32;
  localparam int CAR_WIDTH    = 40;
  localparam int CAR_HEIGHT   = 32;
  localparam int PLAYER_WIDTH = 32;
  localparam int STEP         = 32;
  localparam int PERIOD_W     = 8;
  localparam int N_LANES      = 4;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  // Single car step with horizontal wrap; result always lies in [0, hdisp-1].
  function automatic logic [9:0] wrap_step(input logic [9:0] x, input dir_e dir,
                                           input logic [10:0] step, input logic [10:0] hdisp);
    logic [10:0] s;
    if (dir == DIR_RIGHT) begin
      s = {1'b0, x} + step;
      if (s >= hdisp) s = s - hdisp;
    end else if ({1'b0, x} < step) begin
      s = {1'b0, x} + hdisp - step;
    end else begin
      s = {1'b0, x} - step;
    end
    return s[9:0];
  endfunction

endpackage

// File: rtl/lane_mover.sv
// One lane: frame divider, wrapped car position and the car span hit tests
// against the current pixel and against the player rectangle.
module lane_mover #(
  parameter int LANE_IDX     = 0,
  parameter int N_LANES      = game_pkg::N_LANES,
  parameter int H_DISPLAY    = game_pkg::H_DISPLAY,
  parameter int LANE_Y0      = game_pkg::LANE_Y0,
  parameter int LANE_HEIGHT  = game_pkg::LANE_HEIGHT,
  parameter int CAR_WIDTH    = game_pkg::CAR_WIDTH,
  parameter int CAR_HEIGHT   = game_pkg::CAR_HEIGHT,
  parameter int PLAYER_WIDTH = game_pkg::PLAYER_WIDTH,
  parameter int STEP         = game_pkg::STEP,
  parameter int PERIOD_W     = game_pkg::PERIOD_W
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                frame_tick,
  input  logic                enable,
  input  logic                dir,
  input  logic [PERIOD_W-1:0] period,
  input  logic [9:0]          h_count,
  input  logic [9:0]          v_count,
  input  logic [9:0]          player_x,
  input  logic [9:0]          player_y,
  output logic [9:0]          car_x,
  output logic                pix_hit,
  output logic                overlap
);
  import game_pkg::*;

  localparam logic [9:0]  X_RST = 10'((LANE_IDX * H_DISPLAY / N_LANES) % H_DISPLAY);
  localparam logic [10:0] Y_TOP = 11'(LANE_Y0 + LANE_IDX * LANE_HEIGHT);

  logic [9:0]          x_q, x_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W:0]   cnt_inc;

  // A count at or past the period (period lowered mid-count) steps at once.
  always_comb begin
    x_d     = x_q;
    cnt_d   = cnt_q;
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    if (frame_tick && enable) begin
      if (period == '0) begin
        cnt_d = '0;
      end else if (cnt_inc >= {1'b0, period}) begin
        x_d   = wrap_step(x_q, dir_e'(dir), 11'(STEP), 11'(H_DISPLAY));
        cnt_d = '0;
      end else begin
        cnt_d = cnt_inc[PERIOD_W-1:0];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_q   <= X_RST;
      cnt_q <= '0;
    end else begin
      x_q   <= x_d;
      cnt_q <= cnt_d;
    end
  end

  logic [10:0] x_end, wrap_end, h_w, v_w, px_w, px_end;
  logic        wraps, x_hit, y_hit;

  // Span is [x, x_end) plus, when it runs off the right edge, [0, wrap_end).
  assign x_end    = {1'b0, x_q} + 11'(CAR_WIDTH);
  assign wraps    = x_end > 11'(H_DISPLAY);
  assign wrap_end = x_end - 11'(H_DISPLAY);
  assign h_w      = {1'b0, h_count};
  assign v_w      = {1'b0, v_count};
  assign px_w     = {1'b0, player_x};
  assign px_end   = px_w + 11'(PLAYER_WIDTH);

  assign x_hit   = (h_w >= {1'b0, x_q} && h_w < x_end) || (wraps && h_w < wrap_end);
  assign y_hit   = (v_w >= Y_TOP) && (v_w < Y_TOP + 11'(CAR_HEIGHT));
  assign pix_hit = x_hit && y_hit;
  assign overlap = ({1'b0, player_y} == Y_TOP) &&
                   ((px_w < x_end && {1'b0, x_q} < px_end) || (wraps && px_w < wrap_end));
  assign car_x   = x_q;

endmodule

// File: rtl/lane_traffic_engine.sv
// Multi-lane car engine: per-lane movers, registered car pixel flag and a
// rising-edge player/car collision pulse with lowest-lane priority.
module lane_traffic_engine #(
  parameter int N_LANES        = game_pkg::N_LANES,
  parameter int H_DISPLAY      = game_pkg::H_DISPLAY,
  parameter int LANE_Y0        = game_pkg::LANE_Y0,
  parameter int LANE_HEIGHT    = game_pkg::LANE_HEIGHT,
  parameter int CAR_WIDTH      = game_pkg::CAR_WIDTH,
  parameter int CAR_HEIGHT     = game_pkg::CAR_HEIGHT,
  parameter int PLAYER_WIDTH   = game_pkg::PLAYER_WIDTH,
  parameter int STEP           = game_pkg::STEP,
  parameter int PERIOD_W       = game_pkg::PERIOD_W,
  localparam int LANE_W        = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        frame_tick,
  input  logic                        enable,
  input  logic [N_LANES-1:0]          lane_dir,
  input  logic [N_LANES*PERIOD_W-1:0] lane_period,
  input  logic [9:0]                  h_count,
  input  logic [9:0]                  v_count,
  input  logic [9:0]                  player_x,
  input  logic [9:0]                  player_y,
  output logic                        pixel_car,
  output logic                        collision,
  output logic [LANE_W-1:0]           collision_lane,
  output logic [N_LANES*10-1:0]       car_x_flat
);
  import game_pkg::*;

  logic [N_LANES-1:0] pix_hit, overlap, rise;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    lane_mover #(
      .LANE_IDX(gi), .N_LANES(N_LANES), .H_DISPLAY(H_DISPLAY), .LANE_Y0(LANE_Y0),
      .LANE_HEIGHT(LANE_HEIGHT), .CAR_WIDTH(CAR_WIDTH), .CAR_HEIGHT(CAR_HEIGHT),
      .PLAYER_WIDTH(PLAYER_WIDTH), .STEP(STEP), .PERIOD_W(PERIOD_W)
    ) u_lane (
      .CLK(CLK), .RST_N(RST_N), .frame_tick(frame_tick), .enable(enable),
      .dir(lane_dir[gi]), .period(lane_period[gi*PERIOD_W +: PERIOD_W]),
      .h_count(h_count), .v_count(v_count), .player_x(player_x), .player_y(player_y),
      .car_x(car_x_flat[gi*10 +: 10]), .pix_hit(pix_hit[gi]), .overlap(overlap[gi])
    );
  end

  logic              pixel_car_q, pixel_car_d;
  logic              collision_q, collision_d;
  logic [LANE_W-1:0] lane_q, lane_d, first_lane;
  logic [N_LANES-1:0] overlap_q;

  assign rise = overlap & ~overlap_q;

  always_comb begin
    first_lane = '0;
    for (int i = N_LANES - 1; i >= 0; i--) begin
      if (rise[i]) first_lane = LANE_W'(i);
    end
    pixel_car_d = (h_count < 10'(H_DISPLAY)) && (|pix_hit);
    collision_d = |rise;
    lane_d      = (|rise) ? first_lane : lane_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pixel_car_q <= 1'b0;
      collision_q <= 1'b0;
      lane_q      <= '0;
      overlap_q   <= '0;
    end else begin
      pixel_car_q <= pixel_car_d;
      collision_q <= collision_d;
      lane_q      <= lane_d;
      overlap_q   <= overlap;
    end
  end

  assign pixel_car      = pixel_car_q;
  assign collision      = collision_q;
  assign collision_lane = lane_q;

endmodule

// File: tb/tb_lane_traffic_engine.sv
// Scoreboard bench: driver pushes model predictions, negedge monitor compares.
module tb_lane_traffic_engine;
  localparam int N = 4, H = 640, Y0 = 320, LH = 32, CW = 40, CH = 32, PW = 32, STP = 32, PWID = 8;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            RST_N, frame_tick, enable;
  logic [N-1:0]    lane_dir;
  logic [N*PWID-1:0] lane_period;
  logic [9:0]      h_count, v_count, player_x, player_y;
  logic            pixel_car, collision;
  logic [1:0]      collision_lane;
  logic [N*10-1:0] car_x_flat;

  // Second instance with all lanes sharing one row, to force simultaneous overlaps.
  logic            b_tick;
  logic [N-1:0]    b_dir;
  logic [N*PWID-1:0] b_period;
  logic [9:0]      b_px, b_py, b_zero;
  logic            b_pix, b_col;
  logic [1:0]      b_lane;
  logic [N*10-1:0] b_carx;

  lane_traffic_engine dut (
    .CLK(CLK), .RST_N(RST_N), .frame_tick(frame_tick), .enable(enable),
    .lane_dir(lane_dir), .lane_period(lane_period), .h_count(h_count), .v_count(v_count),
    .player_x(player_x), .player_y(player_y), .pixel_car(pixel_car), .collision(collision),
    .collision_lane(collision_lane), .car_x_flat(car_x_flat)
  );

  lane_traffic_engine #(.LANE_HEIGHT(0)) dut2 (
    .CLK(CLK), .RST_N(RST_N), .frame_tick(b_tick), .enable(1'b1),
    .lane_dir(b_dir), .lane_period(b_period), .h_count(b_zero), .v_count(b_zero),
    .player_x(b_px), .player_y(b_py), .pixel_car(b_pix), .collision(b_col),
    .collision_lane(b_lane), .car_x_flat(b_carx)
  );

  typedef struct {
    logic          pix;
    logic          col;
    logic [1:0]    lane;
    logic [N*10-1:0] carx;
  } exp_t;

  exp_t q[$];
  int   vectors = 0, miscompares = 0;

  int m_x[N], m_cnt[N], m_lane;
  bit m_ov[N];

  localparam logic [N*10-1:0] RST_CARX = {10'd480, 10'd320, 10'd160, 10'd0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic bit xhit(input int x, input int h);
    return (h >= x && h < x + CW) || (x + CW > H && h < x + CW - H);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_x[i] = (i * H / N) % H;
      m_cnt[i] = 0;
      m_ov[i] = 0;
    end
    m_lane = 0;
  endtask

  // Predict outputs after the next edge from current inputs, then advance one clock.
  task automatic cycle();
    exp_t e;
    bit   ov;
    int   first, p;
    e.pix = 0;
    e.col = 0;
    if (!RST_N) begin
      model_reset();
    end else begin
      if (h_count < H)
        for (int i = 0; i < N; i++)
          if (xhit(m_x[i], h_count) && v_count >= Y0 + i*LH && v_count < Y0 + i*LH + CH) e.pix = 1;
      first = -1;
      for (int i = 0; i < N; i++) begin
        ov = 0;
        if (player_y == Y0 + i*LH)
          for (int px = player_x; px < player_x + PW; px++) if (xhit(m_x[i], px)) ov = 1;
        if (ov && !m_ov[i] && first < 0) first = i;
        m_ov[i] = ov;
      end
      if (first >= 0) m_lane = first;
      e.col = (first >= 0);
      if (frame_tick && enable) begin
        for (int i = 0; i < N; i++) begin
          p = lane_period[i*PWID +: PWID];
          if (p == 0) m_cnt[i] = 0;
          else begin
            m_cnt[i]++;
            if (m_cnt[i] >= p) begin
              m_cnt[i] = 0;
              m_x[i] = lane_dir[i] ? (m_x[i] + STP) % H : (m_x[i] - STP + H) % H;
            end
          end
        end
      end
    end
    e.lane = 2'(m_lane);
    for (int i = 0; i < N; i++) e.carx[i*10 +: 10] = 10'(m_x[i]);
    @(posedge CLK);
    q.push_back(e);
    #1;
  endtask

  task automatic tick_frames(input int n, input int gap);
    repeat (n) begin
      frame_tick = 1'b1;
      cycle();
      frame_tick = 1'b0;
      repeat (gap) cycle();
    end
  endtask

  always @(negedge CLK) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pixel_car", pixel_car, e.pix);
      check("collision", collision, e.col);
      check("collision_lane", collision_lane, e.lane);
      check("car_x_flat", car_x_flat, e.carx);
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    RST_N = 1'b0; frame_tick = 1'b0; enable = 1'b0; lane_dir = '0; lane_period = '0;
    h_count = '0; v_count = '0; player_x = '0; player_y = '0;
    b_tick = 1'b0; b_dir = '0; b_period = '0; b_px = '0; b_py = '0; b_zero = '0;

    repeat (3) cycle();
    check("reset_carx", car_x_flat, RST_CARX);
    check("reset_pixel", pixel_car, 1'b0);
    check("reset_collision", collision, 1'b0);
    RST_N = 1'b1;

    // Lane 0 right, one step per tick.
    enable = 1'b1; lane_dir[0] = 1'b1; lane_period[7:0] = 8'd1;
    tick_frames(19, 2);
    check("lane0_19ticks", car_x_flat[9:0], 10'd608);
    tick_frames(1, 2);
    check("lane0_wrap_right", car_x_flat[9:0], 10'd0);
    lane_period[7:0] = 8'd3;
    tick_frames(6, 2);
    check("lane0_period3", car_x_flat[9:0], 10'd64);

    // Lane 0 left across the wrap point.
    lane_dir[0] = 1'b0; lane_period[7:0] = 8'd1;
    tick_frames(2, 1);
    check("lane0_left_to0", car_x_flat[9:0], 10'd0);
    tick_frames(1, 1);
    check("lane0_wrap_left", car_x_flat[9:0], 10'd608);
    enable = 1'b0;
    tick_frames(10, 1);
    check("lane0_disabled", car_x_flat[9:0], 10'd608);
    enable = 1'b1; lane_period[7:0] = 8'd0;
    tick_frames(10, 1);
    check("lane0_period0", car_x_flat[9:0], 10'd608);

    // Wrapped car span on lane 0 row.
    v_count = 10'd320;
    h_count = 10'd5;   cycle(); check("pix_h5", pixel_car, 1'b1);
    h_count = 10'd8;   cycle(); check("pix_h8", pixel_car, 1'b0);
    h_count = 10'd639; cycle(); check("pix_h639", pixel_car, 1'b1);
    h_count = 10'd700; cycle(); check("pix_h700", pixel_car, 1'b0);
    h_count = 10'd0; v_count = 10'd0;

    // Car steps onto the player: one pulse, none while held, new one on re-entry.
    player_y = 10'd320; player_x = 10'd20; lane_dir[0] = 1'b1; lane_period[7:0] = 8'd1;
    repeat (2) cycle();
    frame_tick = 1'b1; cycle(); frame_tick = 1'b0;
    check("no_coll_preupdate", collision, 1'b0);
    cycle();
    check("coll_pulse", collision, 1'b1);
    check("coll_lane0", collision_lane, 2'd0);
    pulses = 0;
    repeat (100) begin cycle(); if (collision) pulses++; end
    check("coll_sustained_pulses", pulses, 0);
    player_x = 10'd300; repeat (3) cycle();
    player_x = 10'd20;  cycle();
    check("coll_reentry", collision, 1'b1);

    // Shared-row instance: lane 3 walks left onto lane 1, then both overlap together.
    b_dir = '0; b_period[3*PWID +: PWID] = 8'd1;
    repeat (10) begin b_tick = 1'b1; cycle(); b_tick = 1'b0; cycle(); end
    check("b_lane3_x", b_carx[39:30], 10'd160);
    check("b_lane1_x", b_carx[19:10], 10'd160);
    b_py = 10'd320; b_px = 10'd170;
    cycle();
    check("b_multi_coll", b_col, 1'b1);
    check("b_multi_lane", b_lane, 2'd1);

    // Asynchronous mid-frame reset.
    player_y = 10'd0;
    lane_period = {8'd2, 8'd1, 8'd3, 8'd1}; lane_dir = 4'b0110;
    tick_frames(3, 2);
    @(negedge CLK); #1;
    RST_N = 1'b0;
    #1;
    check("async_rst_carx", car_x_flat, RST_CARX);
    check("async_rst_b_carx", b_carx, RST_CARX);
    check("async_rst_b_col", b_col, 1'b0);
    repeat (2) cycle();
    RST_N = 1'b1;
    b_py = 10'd0;
    pulses = 0;
    repeat (5) begin cycle(); if (collision || b_col) pulses++; end
    check("no_pulse_on_release", pulses, 0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      frame_tick = ($urandom_range(0, 5) == 0);
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 49) == 0) begin
        lane_dir = 4'($urandom);
        for (int i = 0; i < N; i++) lane_period[i*PWID +: PWID] = 8'($urandom_range(0, 3));
      end
      h_count = 10'($urandom_range(0, 799));
      v_count = 10'($urandom_range(300, 470));
      if ($urandom_range(0, 3) == 0) begin
        player_x = 10'($urandom_range(0, H - 1));
        player_y = ($urandom_range(0, 1) == 0) ? 10'(Y0 + LH * $urandom_range(0, N - 1))
                                               : 10'($urandom_range(300, 470));
      end
      cycle();
    end

    @(negedge CLK); #1;
    @(negedge CLK); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
